// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: pipeline status into the scheduler,
// stall/flush controls and status back out to the pipeline.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start_i;
    logic             IDEX_MemRead_i;
    logic [4:0]       IDEX_RDaddr_i;
    logic [4:0]       IFID_RS1addr_i;
    logic [4:0]       IFID_RS2addr_i;
    logic             EXMEM_MemRead_i;
    logic             EXMEM_MemWrite_i;
    logic             mem_ack_i;
    logic             Branch_i;
    logic             Hazard_o;
    logic             PCWrite_o;
    logic             IFIDWrite_o;
    logic             PipeWrite_o;
    logic             IFFlush_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    // Pipeline side: drives stage status, receives stall/flush controls.
    modport master (
        output start_i, IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1addr_i, IFID_RS2addr_i,
               EXMEM_MemRead_i, EXMEM_MemWrite_i, mem_ack_i, Branch_i,
        input  Hazard_o, PCWrite_o, IFIDWrite_o, PipeWrite_o, IFFlush_o, err_o, stall_cnt_o
    );

    // Scheduler side.
    modport slave (
        input  start_i, IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1addr_i, IFID_RS2addr_i,
               EXMEM_MemRead_i, EXMEM_MemWrite_i, mem_ack_i, Branch_i,
        output Hazard_o, PCWrite_o, IFIDWrite_o, PipeWrite_o, IFFlush_o, err_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage core: load-use bubbles, memory-wait
// freeze with timeout to a sticky error state, taken-branch IF flush and a
// saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 16
) (
    input logic          clk_i,
    input logic          rst_i,
    hazard_ctrl_if.slave hz
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StMemWait,
        StError
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic memreq;
    logic loaduse;
    logic run_rules;
    logic hazard;
    logic pc_we;
    logic ifid_we;
    logic pipe_we;
    logic if_flush;
    logic active;

    // Hazard detection on the current stage contents.
    always_comb begin
        memreq  = hz.EXMEM_MemRead_i | hz.EXMEM_MemWrite_i;
        loaduse = hz.IDEX_MemRead_i && (hz.IDEX_RDaddr_i != 5'd0) &&
                  ((hz.IDEX_RDaddr_i == hz.IFID_RS1addr_i) ||
                   (hz.IDEX_RDaddr_i == hz.IFID_RS2addr_i));
    end

    // Next-state and control outputs; freeze (all zero) is the default.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        run_rules = 1'b0;
        hazard    = 1'b0;
        pc_we     = 1'b0;
        ifid_we   = 1'b0;
        pipe_we   = 1'b0;
        if_flush  = 1'b0;

        unique case (state_q)
            StIdle: begin
                hazard = 1'b1;
                if (hz.start_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (memreq && !hz.mem_ack_i) begin
                    state_d = StMemWait;
                    wait_d  = WAIT_W'(1);
                end else begin
                    run_rules = 1'b1;
                end
            end
            StMemWait: begin
                if (hz.mem_ack_i) begin
                    // Ack cycle behaves like an ordinary RUN cycle.
                    state_d   = StRun;
                    wait_d    = '0;
                    run_rules = 1'b1;
                end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
                    state_d = StError;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StIdle;
                wait_d  = '0;
            end
        endcase

        if (run_rules) begin
            if (loaduse) begin
                // Hold PC and IF/ID; branch is re-evaluated once ID advances.
                hazard  = 1'b1;
                pipe_we = 1'b1;
            end else begin
                pc_we    = 1'b1;
                ifid_we  = 1'b1;
                pipe_we  = 1'b1;
                if_flush = hz.Branch_i;
            end
        end
    end

    // Saturating stall counter; only RUN/MEMWAIT cycles are counted.
    always_comb begin
        active      = (state_q == StRun) || (state_q == StMemWait);
        stall_cnt_d = stall_cnt_q;
        if (active && !pc_we && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State, wait counter and stall counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            wait_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.Hazard_o    = hazard;
    assign hz.PCWrite_o   = pc_we;
    assign hz.IFIDWrite_o = ifid_we;
    assign hz.PipeWrite_o = pipe_we;
    assign hz.IFFlush_o   = if_flush;
    assign hz.err_o       = (state_q == StError);
    assign hz.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (default sizing and MAX_WAIT=4/CNT_W=3)
// share one stimulus stream.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       idex_mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       emr;
        logic       emw;
        logic       ack;
        logic       br;
    } stim_t;

    typedef struct {
        stim_t      in;
        logic [4:0] outs;  // {hazard, pcwrite, ifidwrite, pipewrite, ifflush}
        int         cnt;
    } vec_t;

    localparam logic [4:0] IDL = 5'b10000;
    localparam logic [4:0] NRM = 5'b01110;
    localparam logic [4:0] BUB = 5'b10010;
    localparam logic [4:0] FLS = 5'b01111;
    localparam logic [4:0] FRZ = 5'b00000;

    stim_t s;
    int    n_pass  = 0;
    int    n_total = 0;

    hazard_ctrl_if #(.CNT_W(16)) if_main ();
    hazard_ctrl_if #(.CNT_W(3))  if_small ();

    assign if_main.start_i           = s.start;
    assign if_main.IDEX_MemRead_i    = s.idex_mr;
    assign if_main.IDEX_RDaddr_i     = s.rd;
    assign if_main.IFID_RS1addr_i    = s.rs1;
    assign if_main.IFID_RS2addr_i    = s.rs2;
    assign if_main.EXMEM_MemRead_i   = s.emr;
    assign if_main.EXMEM_MemWrite_i  = s.emw;
    assign if_main.mem_ack_i         = s.ack;
    assign if_main.Branch_i          = s.br;
    assign if_small.start_i          = s.start;
    assign if_small.IDEX_MemRead_i   = s.idex_mr;
    assign if_small.IDEX_RDaddr_i    = s.rd;
    assign if_small.IFID_RS1addr_i   = s.rs1;
    assign if_small.IFID_RS2addr_i   = s.rs2;
    assign if_small.EXMEM_MemRead_i  = s.emr;
    assign if_small.EXMEM_MemWrite_i = s.emw;
    assign if_small.mem_ack_i        = s.ack;
    assign if_small.Branch_i         = s.br;

    hazard_ctrl #(.MAX_WAIT(16), .CNT_W(16)) u_main (
        .clk_i (clk),
        .rst_i (rst_n),
        .hz    (if_main)
    );

    hazard_ctrl #(.MAX_WAIT(4), .CNT_W(3)) u_small (
        .clk_i (clk),
        .rst_i (rst_n),
        .hz    (if_small)
    );

    // Reference model: mode 0 idle, 1 active, 2 error; age = cycles the current
    // memory access has gone unacknowledged.
    int m_mode[2];
    int m_age[2];
    int m_cnt[2];

    function automatic int max_wait(int i);
        return (i == 0) ? 16 : 4;
    endfunction

    function automatic int cnt_max(int i);
        return (i == 0) ? 65535 : 7;
    endfunction

    function automatic logic model_frozen(int i);
        logic memreq;
        memreq = s.emr | s.emw;
        return !s.ack && (m_age[i] > 0 || memreq);
    endfunction

    // {hazard, pcwrite, ifidwrite, pipewrite, ifflush, err}
    function automatic logic [5:0] model_outs(int i);
        logic lu;
        lu = s.idex_mr && (s.rd != 5'd0) && (s.rd == s.rs1 || s.rd == s.rs2);
        if (m_mode[i] == 0) return 6'b100000;
        if (m_mode[i] == 2) return 6'b000001;
        if (model_frozen(i)) return 6'b000000;
        if (lu) return 6'b100100;
        if (s.br) return 6'b011110;
        return 6'b011100;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_age[i]  = 0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic [5:0] e;
            e = model_outs(i);
            if (m_mode[i] == 0) begin
                if (s.start) m_mode[i] = 1;
            end else if (m_mode[i] == 1) begin
                if (!e[4] && m_cnt[i] < cnt_max(i)) m_cnt[i]++;
                if (model_frozen(i)) begin
                    m_age[i]++;
                    if (m_age[i] > max_wait(i)) begin
                        m_mode[i] = 2;
                        m_age[i]  = 0;
                    end
                end else begin
                    m_age[i] = 0;
                end
            end
        end
    endtask

    function automatic logic [5:0] dut_outs(int i);
        if (i == 0)
            return {if_main.Hazard_o, if_main.PCWrite_o, if_main.IFIDWrite_o,
                    if_main.PipeWrite_o, if_main.IFFlush_o, if_main.err_o};
        return {if_small.Hazard_o, if_small.PCWrite_o, if_small.IFIDWrite_o,
                if_small.PipeWrite_o, if_small.IFFlush_o, if_small.err_o};
    endfunction

    function automatic int cnt_of(int i);
        return (i == 0) ? int'(if_main.stall_cnt_o) : int'(if_small.stall_cnt_o);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic clr_s();
        s.start = 0; s.idex_mr = 0; s.rd = 0; s.rs1 = 0; s.rs2 = 0;
        s.emr = 0; s.emw = 0; s.ack = 0; s.br = 0;
    endtask

    // Inputs change at the falling edge; outputs are compared 2 time units later.
    task automatic settle();
        #2;
    endtask

    task automatic advance();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("model%0d_outs", i), int'(dut_outs(i)), int'(model_outs(i)));
            chk($sformatf("model%0d_cnt", i), cnt_of(i), m_cnt[i]);
        end
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_s();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_run();
        s.start = 1; settle(); advance();
        s.start = 0;
    endtask

    function automatic vec_t mk(logic st, logic mr, int rd, int rs1, int rs2, logic emr,
                                logic emw, logic ack, logic br, logic [4:0] o, int c);
        vec_t v;
        v.in.start = st; v.in.idex_mr = mr;
        v.in.rd = 5'(rd); v.in.rs1 = 5'(rs1); v.in.rs2 = 5'(rs2);
        v.in.emr = emr; v.in.emw = emw; v.in.ack = ack; v.in.br = br;
        v.outs = o; v.cnt = c;
        return v;
    endfunction

    vec_t tbl[17];
    int   ack_pct;

    initial begin
        rst_n = 1'b0;
        clr_s();
        model_reset();

        //            st mr rd rs1 rs2 emr emw ack br  outs cnt
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0);
        tbl[3]  = mk(0, 1, 5, 0, 5, 0, 0, 0, 1, BUB, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, FLS, 1);
        tbl[5]  = mk(0, 1, 0, 0, 5, 0, 0, 0, 1, FLS, 1);
        tbl[6]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, FRZ, 1);
        tbl[7]  = mk(0, 1, 5, 5, 0, 1, 0, 0, 0, FRZ, 2);
        tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, FRZ, 3);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, NRM, 4);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 4);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, NRM, 4);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 4);
        tbl[13] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, FRZ, 4);
        tbl[14] = mk(0, 1, 7, 7, 0, 1, 0, 1, 0, BUB, 5);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, FLS, 6);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 6);

        #1;
        chk("reset_hazard", int'(if_main.Hazard_o), 1);
        chk("reset_pcwrite", int'(if_main.PCWrite_o), 0);
        do_reset();

        // Directed table on the default-sized instance.
        for (int k = 0; k < 17; k++) begin
            logic [4:0] got;
            s = tbl[k].in;
            settle();
            got = dut_outs(0)[5:1];
            chk($sformatf("tbl%0d_hazard", k), int'(got[4]), int'(tbl[k].outs[4]));
            chk($sformatf("tbl%0d_pcwrite", k), int'(got[3]), int'(tbl[k].outs[3]));
            chk($sformatf("tbl%0d_ifidwrite", k), int'(got[2]), int'(tbl[k].outs[2]));
            chk($sformatf("tbl%0d_pipewrite", k), int'(got[1]), int'(tbl[k].outs[1]));
            chk($sformatf("tbl%0d_ifflush", k), int'(got[0]), int'(tbl[k].outs[0]));
            chk($sformatf("tbl%0d_err", k), int'(if_main.err_o), 0);
            chk($sformatf("tbl%0d_stallcnt", k), cnt_of(0), tbl[k].cnt);
            advance();
        end

        // Timeout: unacked store, small instance errors after 5 frozen cycles.
        do_reset();
        start_run();
        s.emw = 1; s.ack = 0;
        for (int k = 1; k <= 5; k++) begin
            settle();
            chk($sformatf("to_frz%0d_err", k), int'(if_small.err_o), 0);
            chk($sformatf("to_frz%0d_pipe", k), int'(if_small.PipeWrite_o), 0);
            chk($sformatf("to_frz%0d_hazard", k), int'(if_small.Hazard_o), 0);
            advance();
        end
        for (int k = 1; k <= 20; k++) begin
            settle();
            chk($sformatf("to_err%0d_err", k), int'(if_small.err_o), 1);
            chk($sformatf("to_err%0d_pcwrite", k), int'(if_small.PCWrite_o), 0);
            chk($sformatf("to_err%0d_pipe", k), int'(if_small.PipeWrite_o), 0);
            chk($sformatf("to_err%0d_cnt", k), cnt_of(1), 5);
            advance();
        end
        chk("main_err_after_25", int'(if_main.err_o), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_err_small", int'(if_small.err_o), 0);
        chk("rst_cnt_small", cnt_of(1), 0);
        chk("rst_err_main", int'(if_main.err_o), 0);
        chk("rst_cnt_main", cnt_of(0), 0);
        chk("rst_hazard_small", int'(if_small.Hazard_o), 1);
        model_reset();
        clr_s();
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation: held load-use gives 10 consecutive bubble cycles.
        start_run();
        s.idex_mr = 1; s.rd = 3; s.rs1 = 3;
        for (int k = 0; k < 10; k++) begin
            settle();
            chk($sformatf("sat%0d_small", k), cnt_of(1), (k < 7) ? k : 7);
            advance();
        end
        clr_s();
        settle();
        chk("sat_small_final", cnt_of(1), 7);
        chk("sat_main_final", cnt_of(0), 10);
        advance();

        // Random stimulus against the reference model.
        do_reset();
        ack_pct = 50;
        for (int k = 0; k < 1500; k++) begin
            if (k % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0: ack_pct = 80;
                    1: ack_pct = 50;
                    default: ack_pct = 10;
                endcase
            end
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                rst_n = 1'b1;
            end
            s.start   = ($urandom_range(0, 3) == 0);
            s.idex_mr = ($urandom_range(0, 2) == 0);
            s.rd      = 5'($urandom_range(0, 3));
            s.rs1     = 5'($urandom_range(0, 3));
            s.rs2     = 5'($urandom_range(0, 3));
            s.emr     = ($urandom_range(0, 3) == 0);
            s.emw     = ($urandom_range(0, 3) == 0);
            s.ack     = ($urandom_range(0, 99) < ack_pct);
            s.br      = ($urandom_range(0, 3) == 0);
            settle();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
